iod_tx_train_gen_x2: RTL
========================

Name: iod_tx_train_gen_x2

Overview:
- Transmit-side companion to the x2 RX alignment path.
- Drives the 4-bit parallel word into the TX IOD gearbox and applies the same lane bit-order reversal as the receiver, so the far-end RX sees bits in order.
- Runs a training sequence on request until the far-end RX reports alignment, holds a guard interval, then passes user data through with a ready/valid handshake.

Parameters:
- TRAIN_PATTERN, 4'b0011, raw training word (before reversal).
- IDLE_WORD, 4'b0000, raw word sent when idle or when no valid data is present.
- REV_BITS, 1, 1 = output bit order reversed (out[3:0] = in[0],in[1],in[2],in[3]); 0 = straight.
- MIN_TRAIN_WORDS, 64, minimum number of training words before RX_ALIGN_DONE is honoured.
- TIMEOUT_WORDS, 4096, training words without alignment before a timeout and retry.
- GUARD_WORDS, 8, training words sent after alignment before entering DATA.

Ports:
- SCLK  in  1  fabric clock, rising edge.
- RESETN  in  1  asynchronous active-low reset.
- TRAIN_REQ  in  1  level; high requests (re)training.
- RX_ALIGN_DONE  in  1  far-end alignment status, asynchronous; passes through a 2-flop synchroniser inside this block.
- TX_DATA_IN  in  4  user word.
- TX_DATA_VALID  in  1  user word valid.
- TX_DATA_READY  out  1  block accepts TX_DATA_IN this cycle.
- TX_DATA_OUT  out  4  registered word to the IOD gearbox.
- TRAINING  out  1  high in TRAIN and GUARD.
- TRAIN_TIMEOUT  out  1  sticky flag; set on timeout, cleared on next entry to DATA or by reset.

Behaviour:
- Reset (RESETN low, asynchronous): state IDLE, counter 0, synchroniser 0, TX_DATA_OUT = reversed IDLE_WORD (4'b0000), TX_DATA_READY 0, TRAINING 0, TRAIN_TIMEOUT 0.
- Reversal: a fixed function rev() is applied to every word sent (pattern, idle, data) when REV_BITS=1.
- All outputs are registered. Latency from TX_DATA_IN to TX_DATA_OUT is 1 SCLK.
- Counter: 16 bits, saturating, counts words sent in TRAIN and in GUARD. It resets to 0 on every state entry.
- Alignment status: done_s is RX_ALIGN_DONE after 2 flops, giving 2-cycle recognition latency.
- IDLE: sends IDLE_WORD. TRAIN_REQ=1 moves to TRAIN next cycle.
- TRAIN: sends TRAIN_PATTERN every cycle.
  - If cnt >= MIN_TRAIN_WORDS-1 and done_s=1: move to GUARD.
  - Else if cnt = TIMEOUT_WORDS-1: set TRAIN_TIMEOUT and restart the counter; stay in TRAIN (retry).
  - If done_s and timeout occur in the same cycle, done_s wins.
  - done_s=1 before MIN_TRAIN_WORDS is ignored until the minimum is reached.
- GUARD: sends TRAIN_PATTERN.
  - done_s drops to 0: return to TRAIN.
  - cnt = GUARD_WORDS-1: move to DATA and clear TRAIN_TIMEOUT.
- DATA: TX_DATA_READY=1.
  - Transfer occurs when VALID & READY. Next cycle TX_DATA_OUT = rev(TX_DATA_IN).
  - VALID=0: send IDLE_WORD.
  - TRAIN_REQ=1: go to TRAIN. READY drops in the same registered update, so no word is accepted in the first TRAIN cycle. The last accepted word is still emitted.
- TRAIN_REQ=1 while already in TRAIN or GUARD: no effect; the counter is not restarted.
- TRAIN_REQ held high in DATA: enters TRAIN once, then the TRAIN rules apply.
- done_s dropping while in DATA: no effect; retraining is initiated only by TRAIN_REQ.
- GUARD_WORDS=0: treated as 1.
- Reset asserted mid-sequence: immediate return to reset values. Training restarts only on a new TRAIN_REQ.

Optional Feature:
- Macro TX_TRAIN_PRBS7_EN.
- Defined:
  - TRAIN and GUARD send a PRBS7 stream (x^7+x^6+1, seed 7'h7F), 4 bits per cycle, MSB first, then reversed per REV_BITS.
  - The LFSR resets to the seed on every entry to TRAIN.
  - TRAIN_PATTERN is unused.
- Undefined: the fixed TRAIN_PATTERN is sent and no LFSR logic is present.

Test Plan:
- Reset release, TRAIN_REQ=0 for 20 cycles -> TX_DATA_OUT=4'b0000, READY=0, TRAINING=0 throughout.
- TRAIN_REQ pulse, RX_ALIGN_DONE=1 from cycle 0, defaults -> TX_DATA_OUT=4'b1100 (rev of 0011) for exactly 64+8=72 cycles, then READY=1, TRAINING=0.
- In DATA, drive TX_DATA_IN=4'b0001, VALID=1 -> TX_DATA_OUT=4'b1000 one cycle later. VALID=0 -> 4'b0000. With REV_BITS=0, 4'b0001 -> 4'b0001.
- TRAIN with RX_ALIGN_DONE=0, TIMEOUT_WORDS=100 -> TRAIN_TIMEOUT rises after 100 pattern words and stays in TRAIN. Then assert RX_ALIGN_DONE -> GUARD -> DATA, and TRAIN_TIMEOUT clears on DATA entry.
- RX_ALIGN_DONE deasserted on guard word 3 -> returns to TRAIN and the counter restarts, so at least 64 more pattern words are sent.
- TRAIN_REQ asserted in DATA with VALID=1 -> the last accepted word appears on output, READY=0 next cycle, pattern resumes. Async RESETN pulse mid-GUARD -> outputs at reset values immediately.

Source files
------------

// File: rtl/iod_tx_train_gen_x2.sv
// iod_tx_train_gen_x2: TX-side training generator for the x2 IOD path.
// Sends a training word until the far-end RX reports alignment, holds a
// guard interval, then forwards user data with a ready/valid handshake.
// Every word sent is bit-reversed when REV_BITS=1 to match the RX lane order.
// Optional: define TX_TRAIN_PRBS7_EN to send a PRBS7 stream (x^7+x^6+1,
// seed 7'h7F, 4 bits/cycle MSB first) during TRAIN/GUARD instead of
// TRAIN_PATTERN.
module iod_tx_train_gen_x2 #(
  parameter logic [3:0]  TRAIN_PATTERN   = 4'b0011,
  parameter logic [3:0]  IDLE_WORD       = 4'b0000,
  parameter int unsigned REV_BITS        = 1,
  parameter int unsigned MIN_TRAIN_WORDS = 64,
  parameter int unsigned TIMEOUT_WORDS   = 4096,
  parameter int unsigned GUARD_WORDS     = 8
) (
  input  logic       SCLK,
  input  logic       RESETN,
  input  logic       TRAIN_REQ,
  input  logic       RX_ALIGN_DONE,
  input  logic [3:0] TX_DATA_IN,
  input  logic       TX_DATA_VALID,
  output logic       TX_DATA_READY,
  output logic [3:0] TX_DATA_OUT,
  output logic       TRAINING,
  output logic       TRAIN_TIMEOUT
);

  // A zero-length guard interval still sends one guard word.
  localparam int unsigned GUARD_EFF  = (GUARD_WORDS == 0) ? 1 : GUARD_WORDS;
  localparam logic [15:0] MIN_LAST   = (MIN_TRAIN_WORDS == 0) ? 16'd0 : 16'(MIN_TRAIN_WORDS - 1);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_WORDS - 1);
  localparam logic [15:0] GUARD_LAST = 16'(GUARD_EFF - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRAIN,
    ST_GUARD,
    ST_DATA
  } state_t;

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic        sync1, done_s;
  logic        timeout_set;
  logic        timeout_nx;
  logic        train_nx;
  logic [3:0]  train_word;
  logic [3:0]  out_nx;

  function automatic logic [3:0] rev(input logic [3:0] w);
    return (REV_BITS != 0) ? {w[0], w[1], w[2], w[3]} : w;
  endfunction

  assign train_nx = (state_nx == ST_TRAIN) || (state_nx == ST_GUARD);

`ifdef TX_TRAIN_PRBS7_EN
  localparam logic [6:0] PRBS_SEED = 7'h7F;

  logic [6:0] lfsr, lfsr_nx, lfsr_src, lfsr_adv;

  // Four serial LFSR steps per word; the first bit out lands in the MSB.
  function automatic logic [10:0] prbs4(input logic [6:0] s);
    logic [6:0] st;
    logic [3:0] w;
    st = s;
    w  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w  = {w[2:0], st[6]};
      st = {st[5:0], st[6] ^ st[5]};
    end
    return {w, st};
  endfunction

  // Reseed on every entry to TRAIN, advance only while training words go out.
  always_comb begin
    lfsr_src = ((state_nx == ST_TRAIN) && (state != ST_TRAIN)) ? PRBS_SEED : lfsr;
    {train_word, lfsr_adv} = prbs4(lfsr_src);
    lfsr_nx = train_nx ? lfsr_adv : lfsr;
  end

  // LFSR state register.
  always_ff @(posedge SCLK or negedge RESETN) begin
    if (!RESETN) lfsr <= PRBS_SEED;
    else         lfsr <= lfsr_nx;
  end
`else
  assign train_word = TRAIN_PATTERN;
`endif

  // Two-flop synchroniser for the far-end alignment status.
  always_ff @(posedge SCLK or negedge RESETN) begin
    if (!RESETN) begin
      sync1  <= 1'b0;
      done_s <= 1'b0;
    end else begin
      sync1  <= RX_ALIGN_DONE;
      done_s <= sync1;
    end
  end

  // Next-state, counter, timeout flag and next output word.
  always_comb begin
    state_nx    = state;
    timeout_set = 1'b0;
    case (state)
      ST_IDLE:  if (TRAIN_REQ) state_nx = ST_TRAIN;
      ST_TRAIN: begin
        if ((cnt >= MIN_LAST) && done_s) state_nx = ST_GUARD;
        else if (cnt == TO_LAST)         timeout_set = 1'b1;
      end
      ST_GUARD: begin
        if (!done_s)                 state_nx = ST_TRAIN;
        else if (cnt == GUARD_LAST)  state_nx = ST_DATA;
      end
      ST_DATA:  if (TRAIN_REQ) state_nx = ST_TRAIN;
      default:  state_nx = ST_IDLE;
    endcase

    if ((state_nx != state) || timeout_set)             cnt_nx = '0;
    else if ((state == ST_TRAIN) || (state == ST_GUARD)) cnt_nx = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    else                                                 cnt_nx = '0;

    timeout_nx = TRAIN_TIMEOUT;
    if (timeout_set)                                      timeout_nx = 1'b1;
    else if ((state_nx == ST_DATA) && (state != ST_DATA)) timeout_nx = 1'b0;

    // The word accepted in the last DATA cycle is emitted even when
    // leaving for TRAIN, so DATA decides the output from the current state.
    if (state == ST_DATA) out_nx = TX_DATA_VALID ? rev(TX_DATA_IN) : rev(IDLE_WORD);
    else if (train_nx)    out_nx = rev(train_word);
    else                  out_nx = rev(IDLE_WORD);
  end

  // State, counter and registered outputs.
  always_ff @(posedge SCLK or negedge RESETN) begin
    if (!RESETN) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      TX_DATA_OUT   <= rev(IDLE_WORD);
      TX_DATA_READY <= 1'b0;
      TRAINING      <= 1'b0;
      TRAIN_TIMEOUT <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      TX_DATA_OUT   <= out_nx;
      TX_DATA_READY <= (state_nx == ST_DATA);
      TRAINING      <= train_nx;
      TRAIN_TIMEOUT <= timeout_nx;
    end
  end

endmodule
